vectored_interrupt_controller: RTL and testbench

Parametrised 68000-style interrupt controller. It aggregates up to 8 interrupt sources and gives each a programmable level (0-7) and a per-channel edge or level trigger mode. It drives a registered IPL encoding to the CPU and answers interrupt-acknowledge cycles with a vector byte. It sits on the host register bus next to the other byte-wide peripherals and replaces the fixed-mapping controller.

---
 rtl/vectored_interrupt_controller.sv | 158 +++++++++++++++
 tb/tb_vectored_interrupt_controller.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller: per-channel level and trigger mode, priority
// encoding onto an active-low IPL, and interrupt-acknowledge vector generation.
module vectored_interrupt_controller #(
    parameter int unsigned CHANNELS        = 8,
    parameter logic [7:0]  SPURIOUS_VECTOR = 8'h18
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                chip_enable,
    input  logic                read_write_n,
    input  logic [2:0]          host_address,
    input  logic [7:0]          host_din,
    output logic [7:0]          host_qout,
    input  logic [CHANNELS-1:0] irq,
    input  logic                iack,
    input  logic [2:0]          iack_level,
    output logic                iack_valid,
    output logic [7:0]          iack_vector,
    output logic [2:0]          host_ipl_n
);
    localparam int unsigned NCH = 8;
    localparam logic [NCH-1:0] CHAN_MASK = NCH'((32'd1 << CHANNELS) - 32'd1);

    localparam logic [2:0] ADDR_PEND   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_ENABLE = 3'd2;
    localparam logic [2:0] ADDR_MODE   = 3'd3;
    localparam logic [2:0] ADDR_VBASE  = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;
    localparam logic [2:0] ADDR_LSEL   = 3'd6;
    localparam logic [2:0] ADDR_LEVEL  = 3'd7;

    logic [NCH-1:0] irq_ext;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] sync_prev_q;
    logic [NCH-1:0] pending_q;
    logic [NCH-1:0] enable_q;
    logic [NCH-1:0] mode_q;
    logic [7:0]     vbase_q;
    logic [2:0]     lsel_q;
    logic [2:0]     level_q [NCH];

    logic [NCH-1:0] cand;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] wr_pend;
    logic [NCH-1:0] wr_set;
    logic [NCH-1:0] ack_clr;
    logic [NCH-1:0] edge_next;
    logic [NCH-1:0] pending_next;
    logic           gs;
    logic [2:0]     win_level;
    logic [2:0]     win_chan;
    logic           ack_hit;
    logic [2:0]     ack_chan;
    logic           host_wr;
    logic           lsel_valid;
    logic [7:0]     status;

    assign irq_ext    = NCH'(irq);
    assign host_wr    = chip_enable & ~read_write_n;
    assign lsel_valid = (32'(lsel_q) < CHANNELS);

    // Candidate selection: overall winner and the acknowledge match at iack_level.
    // Ascending scan with >= / == lets the highest index win ties.
    always_comb begin
        cand      = '0;
        gs        = 1'b0;
        win_level = 3'd0;
        win_chan  = 3'd0;
        ack_hit   = 1'b0;
        ack_chan  = 3'd0;
        for (int i = 0; i < NCH; i++) begin
            cand[i] = pending_q[i] & enable_q[i] & CHAN_MASK[i] & (level_q[i] != 3'd0);
            if (cand[i] && (level_q[i] >= win_level)) begin
                gs        = 1'b1;
                win_level = level_q[i];
                win_chan  = 3'(i);
            end
            if (cand[i] && (level_q[i] == iack_level)) begin
                ack_hit  = 1'b1;
                ack_chan = 3'(i);
            end
        end
    end

    // Pending update: edge channels hold with set-over-clear, level channels follow sync.
    always_comb begin
        rise    = sync2_q & ~sync_prev_q;
        wr_pend = (host_wr && (host_address == ADDR_PEND)) ? (host_din & CHAN_MASK) : '0;
        wr_set  = (host_wr && (host_address == ADDR_SET))  ? (host_din & CHAN_MASK) : '0;
        ack_clr = (iack && ack_hit) ? (NCH'(1) << ack_chan) : '0;
        edge_next    = (pending_q & ~(wr_pend | ack_clr)) | rise | wr_set;
        pending_next = ((mode_q & edge_next) | (~mode_q & sync2_q)) & CHAN_MASK;
    end

    assign status = gs ? {1'b1, win_level, 1'b0, win_chan} : 8'h00;

    // Zero-wait register read mux.
    always_comb begin
        host_qout = 8'h00;
        case (host_address)
            ADDR_PEND:   host_qout = pending_q;
            ADDR_SET:    host_qout = sync2_q;
            ADDR_ENABLE: host_qout = enable_q;
            ADDR_MODE:   host_qout = mode_q;
            ADDR_VBASE:  host_qout = vbase_q;
            ADDR_STATUS: host_qout = status;
            ADDR_LSEL:   host_qout = {5'b0, lsel_q};
            ADDR_LEVEL:  host_qout = lsel_valid ? {5'b0, level_q[lsel_q]} : 8'h00;
            default:     host_qout = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync_prev_q <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            mode_q      <= '0;
            vbase_q     <= 8'h40;
            lsel_q      <= 3'd0;
            for (int i = 0; i < NCH; i++) begin
                level_q[i] <= 3'd0;
            end
            host_ipl_n  <= 3'b111;
            iack_valid  <= 1'b0;
            iack_vector <= 8'h00;
        end else begin
            sync1_q     <= irq_ext & CHAN_MASK;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            pending_q   <= pending_next;
            host_ipl_n  <= gs ? ~win_level : 3'b111;
            iack_valid  <= iack;
            if (iack) begin
                iack_vector <= ack_hit ? {vbase_q[7:3], ack_chan} : SPURIOUS_VECTOR;
            end
            if (host_wr) begin
                case (host_address)
                    ADDR_ENABLE: enable_q <= host_din & CHAN_MASK;
                    ADDR_MODE:   mode_q   <= host_din & CHAN_MASK;
                    ADDR_VBASE:  vbase_q  <= host_din;
                    ADDR_LSEL:   lsel_q   <= host_din[2:0];
                    ADDR_LEVEL: begin
                        if (lsel_valid) begin
                            level_q[lsel_q] <= host_din[2:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Bench for vectored_interrupt_controller: register table, directed corner
// sequences, and randomized traffic against a behavioural model.
module tb_vectored_interrupt_controller;
    localparam int unsigned CH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          chip_enable = 1'b0;
    logic          read_write_n = 1'b1;
    logic [2:0]    host_address = 3'd0;
    logic [7:0]    host_din = 8'h00;
    logic [7:0]    host_qout;
    logic [CH-1:0] irq = '0;
    logic          iack = 1'b0;
    logic [2:0]    iack_level = 3'd0;
    logic          iack_valid;
    logic [7:0]    iack_vector;
    logic [2:0]    host_ipl_n;

    int total = 0;
    int bad   = 0;

    vectored_interrupt_controller #(.CHANNELS(CH), .SPURIOUS_VECTOR(8'h18)) dut (
        .clock(clock), .reset(reset), .chip_enable(chip_enable),
        .read_write_n(read_write_n), .host_address(host_address),
        .host_din(host_din), .host_qout(host_qout), .irq(irq), .iack(iack),
        .iack_level(iack_level), .iack_valid(iack_valid),
        .iack_vector(iack_vector), .host_ipl_n(host_ipl_n)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Behavioural model: irq history line, per-channel arrays, searched priority.
    bit [7:0] m_h1, m_h2, m_h3, m_pend, m_en, m_mode, m_vbase, m_ivec;
    bit [2:0] m_lsel, m_ipl;
    bit       m_iv;
    int       m_lvl [8];
    bit [7:0] n_h1, n_h2, n_h3, n_pend, n_en, n_mode, n_vbase, n_ivec;
    bit [2:0] n_lsel, n_ipl;
    bit       n_iv;
    int       n_lvl [8];

    function automatic bit is_cand(int c);
        return m_pend[c] && m_en[c] && (m_lvl[c] != 0);
    endfunction

    function automatic int best_level();
        for (int l = 7; l >= 1; l--)
            for (int c = 7; c >= 0; c--)
                if (is_cand(c) && m_lvl[c] == l) return l;
        return 0;
    endfunction

    function automatic int best_chan(int l);
        for (int c = 7; c >= 0; c--)
            if (is_cand(c) && m_lvl[c] == l) return c;
        return -1;
    endfunction

    function automatic bit [7:0] model_read(bit [2:0] a);
        int lv;
        case (a)
            3'd0: return m_pend;
            3'd1: return m_h2;
            3'd2: return m_en;
            3'd3: return m_mode;
            3'd4: return m_vbase;
            3'd5: begin
                lv = best_level();
                if (lv == 0) return 8'h00;
                return {1'b1, 3'(lv), 1'b0, 3'(best_chan(lv))};
            end
            3'd6: return {5'b0, m_lsel};
            default: return 8'(m_lvl[m_lsel]);
        endcase
    endfunction

    task automatic model_step();
        int  ack_ch;
        int  lv;
        bit  wr;
        n_h1 = m_h1; n_h2 = m_h2; n_h3 = m_h3; n_pend = m_pend; n_en = m_en;
        n_mode = m_mode; n_vbase = m_vbase; n_ivec = m_ivec; n_lsel = m_lsel;
        n_ipl = m_ipl; n_iv = m_iv; n_lvl = m_lvl;
        if (reset) begin
            n_h1 = 0; n_h2 = 0; n_h3 = 0; n_pend = 0; n_en = 0; n_mode = 0;
            n_vbase = 8'h40; n_lsel = 0; n_ipl = 3'b111; n_iv = 0; n_ivec = 8'h00;
            for (int c = 0; c < 8; c++) n_lvl[c] = 0;
        end else begin
            wr = chip_enable && !read_write_n;
            ack_ch = -1;
            if (iack) begin
                for (int c = 7; c >= 0; c--)
                    if (ack_ch < 0 && is_cand(c) && m_lvl[c] == int'(iack_level)) ack_ch = c;
                n_ivec = (ack_ch >= 0) ? {m_vbase[7:3], 3'(ack_ch)} : 8'h18;
            end
            n_iv = iack;
            lv = best_level();
            n_ipl = (lv > 0) ? 3'(7 - lv) : 3'b111;
            for (int c = 0; c < 8; c++) begin
                if (m_mode[c]) begin
                    if ((m_h2[c] && !m_h3[c]) || (wr && host_address == 3'd1 && host_din[c]))
                        n_pend[c] = 1'b1;
                    else if ((wr && host_address == 3'd0 && host_din[c]) || ack_ch == c)
                        n_pend[c] = 1'b0;
                end else begin
                    n_pend[c] = m_h2[c];
                end
            end
            n_h1 = irq; n_h2 = m_h1; n_h3 = m_h2;
            if (wr) begin
                case (host_address)
                    3'd2: n_en = host_din;
                    3'd3: n_mode = host_din;
                    3'd4: n_vbase = host_din;
                    3'd6: n_lsel = host_din[2:0];
                    3'd7: n_lvl[m_lsel] = int'(host_din[2:0]);
                    default: ;
                endcase
            end
        end
    endtask

    task automatic model_commit();
        m_h1 = n_h1; m_h2 = n_h2; m_h3 = n_h3; m_pend = n_pend; m_en = n_en;
        m_mode = n_mode; m_vbase = n_vbase; m_ivec = n_ivec; m_lsel = n_lsel;
        m_ipl = n_ipl; m_iv = n_iv; m_lvl = n_lvl;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        model_commit();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        chip_enable = 1'b1; read_write_n = 1'b0; host_address = a; host_din = d;
        tick();
        chip_enable = 1'b0; read_write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string n);
        host_address = a;
        #1;
        chk(n, host_qout, e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [16];

    initial begin
        vt[0]  = '{1'b0, 3'd0, 8'h00, 8'h00};
        vt[1]  = '{1'b0, 3'd1, 8'h00, 8'h00};
        vt[2]  = '{1'b0, 3'd2, 8'h00, 8'h00};
        vt[3]  = '{1'b0, 3'd3, 8'h00, 8'h00};
        vt[4]  = '{1'b0, 3'd4, 8'h00, 8'h40};
        vt[5]  = '{1'b0, 3'd5, 8'h00, 8'h00};
        vt[6]  = '{1'b0, 3'd6, 8'h00, 8'h00};
        vt[7]  = '{1'b0, 3'd7, 8'h00, 8'h00};
        vt[8]  = '{1'b1, 3'd2, 8'hff, 8'hff};
        vt[9]  = '{1'b1, 3'd3, 8'ha5, 8'ha5};
        vt[10] = '{1'b1, 3'd4, 8'h9c, 8'h9c};
        vt[11] = '{1'b1, 3'd5, 8'h3c, 8'h00};
        vt[12] = '{1'b1, 3'd6, 8'hfd, 8'h05};
        vt[13] = '{1'b1, 3'd7, 8'hff, 8'h07};
        vt[14] = '{1'b1, 3'd6, 8'h02, 8'h02};
        vt[15] = '{1'b0, 3'd7, 8'h00, 8'h00};

        do_reset();
        chk("rst_ipl", 8'(host_ipl_n), 8'h07);
        chk("rst_iack_valid", 8'(iack_valid), 8'h00);
        for (int i = 0; i < 16; i++) begin
            if (vt[i].we) wr(vt[i].addr, vt[i].din);
            rd(vt[i].addr, vt[i].exp, $sformatf("tbl%0d", i));
        end

        // Edge channel 2 at level 5
        do_reset();
        wr(3'd6, 8'h02); wr(3'd7, 8'h05); wr(3'd3, 8'h04); wr(3'd2, 8'h04);
        irq = 8'h04; tick(); irq = 8'h00; tick(); tick();
        rd(3'd0, 8'h04, "edge_pend");
        chk("edge_ipl_early", 8'(host_ipl_n), 8'h07);
        tick();
        chk("edge_ipl", 8'(host_ipl_n), 8'h02);
        rd(3'd5, 8'hd2, "edge_status");

        // Tie at level 4: ch6 edge, ch1 level; back-to-back acknowledge
        do_reset();
        wr(3'd4, 8'h60); wr(3'd6, 8'h01); wr(3'd7, 8'h04);
        wr(3'd6, 8'h06); wr(3'd7, 8'h04); wr(3'd3, 8'h40); wr(3'd2, 8'h42);
        irq = 8'h42; tick(); tick(); tick();
        rd(3'd0, 8'h42, "tie_pend");
        iack = 1'b1; iack_level = 3'd4; tick();
        chk("ack1_valid", 8'(iack_valid), 8'h01);
        chk("ack1_vector", iack_vector, 8'h66);
        tick(); iack = 1'b0;
        chk("ack2_valid", 8'(iack_valid), 8'h01);
        chk("ack2_vector", iack_vector, 8'h61);
        tick();
        chk("ack_pulse_end", 8'(iack_valid), 8'h00);
        chk("ack_vector_hold", iack_vector, 8'h61);
        rd(3'd0, 8'h02, "ack_pend_after");
        chk("ack_ipl", 8'(host_ipl_n), 8'h03);

        // Spurious acknowledge
        iack = 1'b1; iack_level = 3'd3; tick(); iack = 1'b0;
        chk("spur_valid", 8'(iack_valid), 8'h01);
        chk("spur_vector", iack_vector, 8'h18);
        rd(3'd0, 8'h02, "spur_pend");

        // Level channel 0 at level 7 ignores PEND writes
        do_reset();
        wr(3'd7, 8'h07); wr(3'd2, 8'h01);
        irq = 8'h01; tick(); tick(); tick();
        rd(3'd0, 8'h01, "lvl_pend");
        tick();
        chk("lvl_ipl", 8'(host_ipl_n), 8'h00);
        wr(3'd0, 8'h01);
        rd(3'd0, 8'h01, "lvl_pend_write");
        irq = 8'h00; tick(); tick(); tick();
        rd(3'd0, 8'h00, "lvl_drop_pend");
        chk("lvl_drop_ipl_early", 8'(host_ipl_n), 8'h00);
        tick();
        chk("lvl_drop_ipl", 8'(host_ipl_n), 8'h07);

        // Set beats clear on ch3, then ack, then reset with an ack in flight
        do_reset();
        wr(3'd3, 8'h08); wr(3'd2, 8'h08); wr(3'd6, 8'h03); wr(3'd7, 8'h02);
        irq = 8'h08; tick(); tick();
        wr(3'd0, 8'h08);
        rd(3'd0, 8'h08, "setwin_pend");
        iack = 1'b1; iack_level = 3'd2; tick(); iack = 1'b0;
        chk("e_ack_vector", iack_vector, 8'h43);
        rd(3'd0, 8'h00, "e_ack_pend");
        iack = 1'b1; reset = 1'b1; tick(); reset = 1'b0; iack = 1'b0;
        chk("rst_mid_valid", 8'(iack_valid), 8'h00);
        chk("rst_mid_vector", iack_vector, 8'h00);
        chk("rst_mid_ipl", 8'(host_ipl_n), 8'h07);
        for (int i = 0; i < 8; i++) rd(vt[i].addr, vt[i].exp, $sformatf("rst_mid%0d", i));
        irq = 8'h00;

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
            chip_enable  = ($urandom_range(0, 2) == 0);
            read_write_n = 1'($urandom_range(0, 1));
            host_address = 3'($urandom);
            host_din     = 8'($urandom);
            iack         = ($urandom_range(0, 3) == 0);
            iack_level   = 3'($urandom);
            reset        = ($urandom_range(0, 199) == 0);
            tick();
            reset = 1'b0; iack = 1'b0; chip_enable = 1'b0; read_write_n = 1'b1;
            chk("rnd_ipl", 8'(host_ipl_n), 8'(m_ipl));
            chk("rnd_iack_valid", 8'(iack_valid), 8'(m_iv));
            chk("rnd_iack_vector", iack_vector, m_ivec);
            host_address = 3'($urandom);
            #1;
            chk($sformatf("rnd_read%0d", host_address), host_qout, model_read(host_address));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
